mpu_sample_seq: RTL



---
 rtl/mpu_pkg.sv | 39 +++
 rtl/mpu_word_pack.sv | 60 ++++++
 rtl/mpu_sample_seq.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared states, MPU9250 register map and byte-walk helper for the sample sequencer
package mpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE,
        DONE
    } state_t;

    localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
    localparam logic [7:0] TEMP_OUT_H   = 8'h41;
    localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
    localparam logic [7:0] GYRO_ZOUT_L  = 8'h48;
    localparam logic [7:0] READ_BIT     = 8'h80;

    localparam int W_AX    = 0;
    localparam int W_AY    = 1;
    localparam int W_AZ    = 2;
    localparam int W_TEMP  = 3;
    localparam int W_GX    = 4;
    localparam int W_GY    = 5;
    localparam int W_GZ    = 6;
    localparam int N_WORDS = 7;

    // Byte indices are offsets from ACCEL_XOUT_H, so word index is always idx>>1.
    localparam logic [3:0] IDX_LAST   = 4'(GYRO_ZOUT_L - ACCEL_XOUT_H);
    localparam logic [3:0] IDX_TEMP_H = 4'(TEMP_OUT_H - ACCEL_XOUT_H);
    localparam logic [3:0] IDX_GYRO_H = 4'(GYRO_XOUT_H - ACCEL_XOUT_H);

    function automatic logic [3:0] next_idx(input logic [3:0] idx, input logic temp_en);
        if (!temp_en && idx == IDX_TEMP_H - 4'd1)
            next_idx = IDX_GYRO_H;
        else
            next_idx = idx + 4'd1;
    endfunction

endpackage

// File: rtl/mpu_word_pack.sv
// rtl/mpu_word_pack.sv - shadow word file with byte writes and atomic copy-out; MPU_SEQ_TEMP_EN keeps temp
module mpu_word_pack
    import mpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        wr_en,
    input  logic [3:0]  wr_idx,
    input  logic [7:0]  wr_data,
    input  logic        commit,
    output logic [15:0] ax,
    output logic [15:0] ay,
    output logic [15:0] az,
    output logic [15:0] temp,
    output logic [15:0] gx,
    output logic [15:0] gy,
    output logic [15:0] gz
);

    logic [N_WORDS-1:0][15:0] shadow;
    logic [N_WORDS-1:0][15:0] shadow_nx;
    logic [N_WORDS-1:0][15:0] out_q;

    // Commit copies the merged view so the final byte lands in the same cycle.
    always_comb begin
        shadow_nx = shadow;
        if (clear) begin
            shadow_nx = '0;
        end else if (wr_en) begin
            if (wr_idx[0])
                shadow_nx[wr_idx[3:1]][7:0] = wr_data;
            else
                shadow_nx[wr_idx[3:1]][15:8] = wr_data;
        end
`ifndef MPU_SEQ_TEMP_EN
        shadow_nx[W_TEMP] = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            out_q  <= '0;
        end else begin
            shadow <= shadow_nx;
            if (commit)
                out_q <= shadow_nx;
        end
    end

    assign ax   = out_q[W_AX];
    assign ay   = out_q[W_AY];
    assign az   = out_q[W_AZ];
    assign temp = out_q[W_TEMP];
    assign gx   = out_q[W_GX];
    assign gy   = out_q[W_GY];
    assign gz   = out_q[W_GZ];

endmodule

// File: rtl/mpu_sample_seq.sv
// rtl/mpu_sample_seq.sv - MPU9250 burst sampler over a single-register SPI reader; MPU_SEQ_TEMP_EN reads temp
module mpu_sample_seq
    import mpu_pkg::*;
#(
    parameter int         TIMEOUT_BITS = 12,
    parameter logic [7:0] BASE_ADDR    = 8'h3B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trig,
    output logic        spi_start,
    output logic [7:0]  spi_addr,
    input  logic        spi_busy,
    input  logic        spi_finish,
    input  logic [7:0]  spi_get,
    output logic [15:0] ax,
    output logic [15:0] ay,
    output logic [15:0] az,
    output logic [15:0] temp,
    output logic [15:0] gx,
    output logic [15:0] gy,
    output logic [15:0] gz,
    output logic        sample_valid,
    output logic        busy,
    output logic        err,
    output logic [7:0]  overrun_cnt
);

`ifdef MPU_SEQ_TEMP_EN
    localparam logic TEMP_EN = 1'b1;
`else
    localparam logic TEMP_EN = 1'b0;
`endif

    localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {TIMEOUT_BITS{1'b1}} - 1'b1;

    state_t                  state, state_nx;
    logic [3:0]              idx;
    logic [7:0]              byte_q;
    logic [TIMEOUT_BITS-1:0] wdog;
    logic                    wd_hit, wr_en, commit, clear;
    logic [3:0]              issue_idx;
    logic [7:0]              issue_addr;

    always_comb begin
        state_nx = state;
        wd_hit   = 1'b0;
        wr_en    = 1'b0;
        commit   = 1'b0;
        clear    = 1'b0;
        case (state)
            IDLE:  if (trig && !spi_busy) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (spi_finish) begin
                    state_nx = STORE;
                end else if (wdog == WD_LAST) begin
                    wd_hit   = 1'b1;
                    clear    = 1'b1;
                    state_nx = IDLE;
                end
            end
            STORE: begin
                wr_en = 1'b1;
                if (idx == IDX_LAST) begin
                    commit   = 1'b1;
                    state_nx = DONE;
                end else begin
                    state_nx = ISSUE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign issue_idx  = (state == IDLE) ? 4'd0 : next_idx(idx, TEMP_EN);
    assign issue_addr = BASE_ADDR + {4'd0, issue_idx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            byte_q      <= '0;
            wdog        <= '0;
            spi_addr    <= '0;
            err         <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state <= state_nx;
            err   <= wd_hit;
            case (state)
                IDLE:  idx  <= '0;
                ISSUE: wdog <= '0;
                WAIT: begin
                    if (spi_finish)
                        byte_q <= spi_get;
                    else
                        wdog <= wdog + 1'b1;
                end
                STORE: if (idx != IDX_LAST) idx <= next_idx(idx, TEMP_EN);
                default: ;
            endcase
            if (state_nx == ISSUE)
                spi_addr <= {1'b1, issue_addr[6:0]};
            if (trig && (state != IDLE || spi_busy) && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    assign spi_start    = (state == ISSUE);
    assign busy         = (state != IDLE);
    assign sample_valid = (state == DONE);

    mpu_word_pack u_pack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (byte_q),
        .commit  (commit),
        .ax      (ax),
        .ay      (ay),
        .az      (az),
        .temp    (temp),
        .gx      (gx),
        .gy      (gy),
        .gz      (gz)
    );

endmodule
